ahim_rx_router: RTL and testbench
=================================

Name: ahim_rx_router

Overview:
- Parametrised next-generation HPS-to-fabric receive unit for the AHIM interface.
- Accepts PIO beats under an Avalon-style write/waitrequest handshake and packs BEATS_PER_WORD beats into one wide word.
- Routes each packed word to one of N_DEST destination buffers (image RAM, breakpoint RAM, …) with an auto-incrementing address.
- Signals burst completion, watchdog timeout and overflow.

Parameters:
- DATA_W, 32: PIO beat width.
- BEATS_PER_WORD, 4: beats packed per destination word (≥1).
- N_DEST, 2: number of destination buffers (≥2).
- ADDR_W, 12: destination address width.
- CNT_W, 16: expected-word counter width.
- WD_W, 16: watchdog counter width.

Ports:
- clk_in, in, 1: single clock.
- rst_n, in, 1: synchronous, active-low reset.
- clear_buff, in, 1: synchronous soft clear.
- rx_enable, in, 1: session enable from HPS control.
- dest_sel, in, $clog2(N_DEST): destination index, sampled at session start.
- watchdog_conf, in, WD_W: stall limit in cycles; 0 disables the watchdog.
- expected_words, in, CNT_W: packed words in the session, sampled at session start.
- pio_data, in, DATA_W: beat data.
- write, in, 1: beat valid.
- waitrequest_out, out, 1: 1 means the beat is not accepted.
- wr_en, out, N_DEST: one-hot destination write strobe.
- wr_data, out, DATA_W*BEATS_PER_WORD: packed word; beat 0 in the LSBs.
- wr_addr, out, ADDR_W: destination address.
- rx_done, out, 1: one-cycle completion pulse.
- watchdog_trigger, out, 1: level, timeout occurred.
- overflow_err, out, 1: sticky error.
- rx_checksum, out, DATA_W: see Optional Feature.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low on rst_n, sampled at posedge clk_in.
- Reset values: state=IDLE; waitrequest_out=1; all other outputs and all counters 0.
- Priority: rst_n > clear_buff > FSM.
- clear_buff: same effect as reset; also clears overflow_err.
- A beat is accepted in a cycle where write=1 and waitrequest_out=0. waitrequest_out is a registered output.
- FSM states: IDLE, RECV, DONE, TIMEOUT.

FSM transitions:
- IDLE:
  - waitrequest_out=1.
  - A registered rising edge of rx_enable latches dest_sel and expected_words, clears beat_cnt, word_cnt and watchdog, then moves to RECV.
  - If the latched expected_words==0, move to DONE instead and pulse rx_done.
- RECV:
  - waitrequest_out=0.
  - An accepted beat is stored at slot beat_cnt and beat_cnt increments.
  - On the beat with beat_cnt==BEATS_PER_WORD-1, beat_cnt wraps to 0. On the next cycle:
    - wr_en[dest] pulses for 1 cycle;
    - wr_data holds the packed word;
    - wr_addr = word_cnt[ADDR_W-1:0];
    - word_cnt increments.
  - Write latency: last beat accepted at cycle N gives wr_en at N+1.
  - When the final word's wr_en pulses, rx_done pulses in the same cycle and the FSM moves to DONE.
- DONE:
  - waitrequest_out=1.
  - Beats presented here (write=1) are dropped and set overflow_err.
  - rx_enable low moves the FSM to IDLE.
- TIMEOUT:
  - watchdog_trigger=1 and waitrequest_out=1.
  - Exits to IDLE on rx_enable low or clear_buff; watchdog_trigger clears on exit.

Watchdog:
- Active in RECV only when watchdog_conf≠0.
- Counts cycles with no accepted beat and resets on each accepted beat.
- When the counter reaches watchdog_conf, the FSM enters TIMEOUT on the next cycle.

Boundary conditions:
- rx_enable low during RECV: abort to IDLE. A partial word is discarded; no wr_en, no rx_done.
- Address wrap: if word_cnt ≥ 2**ADDR_W when a word is written, the word is still written at the wrapped address and overflow_err is set.
- Simultaneous last beat and rx_enable fall: the abort wins; the word is not written.
- Arithmetic: all counters are unsigned and wrap modulo 2^width.

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined:
  - rx_checksum = running sum, mod 2^DATA_W, of every accepted beat in the session.
  - Cleared at session start and by clear_buff.
  - Valid and stable from the rx_done cycle until the next session start.
- Undefined: rx_checksum is tied to 0 and no adder is built.

Decomposition:
- ahim_config_pkg holds:
  - rx_state_t enum (IDLE, RECV, DONE, TIMEOUT);
  - default constants RX_BEATS_PER_WORD, RX_N_DEST, RX_WD_DEPTH; existing IMAGE_RAM_WIDTH, UINT16_WIDTH and PIO_DATA_WIDTH feed ADDR_W, CNT_W and DATA_W.
- Sub-module rx_beat_packer: holds beat_cnt and the shift/slot register, and outputs word_valid plus the packed word. The FSM, watchdog and routing stay in the top.

Test Plan:
- Basic, BEATS=4, expected_words=2, dest_sel=1: 8 back-to-back beats 0x1..0x8 →
  - wr_en=2'b10 at addr 0 with 0x4_3_2_1 (beat order), then addr 1 with 0x8_7_6_5;
  - rx_done pulses with the 2nd wr_en;
  - waitrequest_out=1 afterward.
- Watchdog, watchdog_conf=5: write stalls for 6 cycles mid-word → TIMEOUT, watchdog_trigger=1, no wr_en. rx_enable low → trigger clears, FSM returns to IDLE.
- Abort: rx_enable drops after 2 of 4 beats → no wr_en, no rx_done, next session starts at addr 0.
- Overflow, ADDR_W=2, expected_words=5: 5th word is written at addr 0 and overflow_err=1 (sticky); clear_buff clears it.
- DONE: extra beat after rx_done → dropped, overflow_err=1. expected_words=0 → rx_done one cycle after session start, no wr_en.
- RX_CHECKSUM_EN defined: beats 0xFFFFFFFF,0x2,0x3,0x4 → rx_checksum=0x00000008 at rx_done.

Source files
------------

// File: rtl/ahim_config_pkg.sv
// ahim_config_pkg
// Shared configuration for the AHIM receive path: the receive FSM state type
// and the default widths/depths used as parameter defaults by ahim_rx_router.
// No ports (package).
package ahim_config_pkg;

  // Existing interface widths
  localparam int PIO_DATA_WIDTH  = 32;  // HPS PIO beat width
  localparam int IMAGE_RAM_WIDTH = 12;  // image RAM address width
  localparam int UINT16_WIDTH    = 16;  // generic 16-bit counter width

  // Receive-router defaults
  localparam int RX_BEATS_PER_WORD = 4;
  localparam int RX_N_DEST         = 2;
  localparam int RX_WD_DEPTH       = 16;  // watchdog counter width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_beat_packer.sv
// rx_beat_packer
// Collects BEATS_PER_WORD accepted beats into one wide word, beat 0 in the LSBs.
// word_valid/word are combinational and valid in the cycle the last beat of a
// word is accepted, so the owner can register the destination write directly.
// Ports:
//   clk_in, rst_n (sync, active-low)  clock and reset
//   clear       drop any partial word (beat_cnt back to 0)
//   accept      a beat is taken this cycle
//   beat_data   data of the accepted beat
//   word_valid  this accepted beat completes a word
//   word        packed word (stored beats plus the current beat in the top slot)
module rx_beat_packer #(
  parameter int DATA_W         = 32,
  parameter int BEATS_PER_WORD = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             accept,
  input  logic [DATA_W-1:0]                beat_data,
  output logic                             word_valid,
  output logic [DATA_W*BEATS_PER_WORD-1:0] word
);

  localparam int BC_W = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam logic [BC_W-1:0] LAST = BC_W'(BEATS_PER_WORD - 1);

  logic [BC_W-1:0]   beat_cnt;
  logic [DATA_W-1:0] slot [BEATS_PER_WORD];

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      for (int i = 0; i < BEATS_PER_WORD; i++) slot[i] <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (accept) begin
      slot[beat_cnt] <= beat_data;
      beat_cnt       <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign word_valid = accept && (beat_cnt == LAST);

  // The last beat bypasses its slot so the word is complete in its accept cycle.
  always_comb begin
    word = '0;
    for (int i = 0; i < BEATS_PER_WORD; i++) word[i*DATA_W +: DATA_W] = slot[i];
    word[(BEATS_PER_WORD-1)*DATA_W +: DATA_W] = beat_data;
  end

endmodule

// File: rtl/ahim_rx_router.sv
// ahim_rx_router
// HPS-to-fabric receive unit: accepts PIO beats under a write/waitrequest
// handshake, packs them into words and writes each word to the selected
// destination buffer at an auto-incrementing address. Reports completion,
// watchdog timeout and overflow.
// Optional build macro: RX_CHECKSUM_EN -- when defined, rx_checksum carries the
// running sum of accepted beats in the session; otherwise it is tied to 0.
// Ports:
//   clk_in, rst_n (sync, active-low), clear_buff (soft clear, also clears overflow_err)
//   rx_enable, dest_sel, expected_words, watchdog_conf   session control
//   pio_data, write, waitrequest_out                    beat handshake
//   wr_en (one-hot), wr_data, wr_addr                   destination write port
//   rx_done (pulse), watchdog_trigger (level), overflow_err (sticky), rx_checksum
//
// state   | meaning
// IDLE    | waiting for a rising edge of rx_enable
// RECV    | accepting beats, writing packed words
// DONE    | all words written; further beats dropped and flagged
// TIMEOUT | watchdog expired; waiting for rx_enable low
module ahim_rx_router
  import ahim_config_pkg::*;
#(
  parameter int DATA_W         = PIO_DATA_WIDTH,
  parameter int BEATS_PER_WORD = RX_BEATS_PER_WORD,
  parameter int N_DEST         = RX_N_DEST,
  parameter int ADDR_W         = IMAGE_RAM_WIDTH,
  parameter int CNT_W          = UINT16_WIDTH,
  parameter int WD_W           = RX_WD_DEPTH
) (
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic                             clear_buff,
  input  logic                             rx_enable,
  input  logic [$clog2(N_DEST)-1:0]        dest_sel,
  input  logic [WD_W-1:0]                  watchdog_conf,
  input  logic [CNT_W-1:0]                 expected_words,
  input  logic [DATA_W-1:0]                pio_data,
  input  logic                             write,
  output logic                             waitrequest_out,
  output logic [N_DEST-1:0]                wr_en,
  output logic [DATA_W*BEATS_PER_WORD-1:0] wr_data,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic                             rx_done,
  output logic                             watchdog_trigger,
  output logic                             overflow_err,
  output logic [DATA_W-1:0]                rx_checksum
);

  localparam int DS_W = $clog2(N_DEST);

  rx_state_t                         state;
  logic                              rx_en_q;
  logic [DS_W-1:0]                   dest_q;
  logic [CNT_W-1:0]                  exp_q;
  logic [CNT_W-1:0]                  word_cnt;
  logic [CNT_W-1:0]                  word_cnt_nxt;
  logic [WD_W-1:0]                   wd_cnt;
  logic                              rise;
  logic                              accept;
  logic                              packer_clear;
  logic                              word_valid;
  logic [DATA_W*BEATS_PER_WORD-1:0]  packed_word;

  assign rise         = rx_enable && !rx_en_q;
  // A beat arriving as rx_enable falls is not taken: abort beats the last beat.
  assign accept       = (state == RECV) && !waitrequest_out && write && rx_enable;
  assign packer_clear = clear_buff || (state != RECV);
  assign word_cnt_nxt = word_cnt + 1'b1;

  rx_beat_packer #(
    .DATA_W        (DATA_W),
    .BEATS_PER_WORD(BEATS_PER_WORD)
  ) u_packer (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clear     (packer_clear),
    .accept    (accept),
    .beat_data (pio_data),
    .word_valid(word_valid),
    .word      (packed_word)
  );

  // Follows rx_enable through clear_buff so a held-high enable does not restart.
  always_ff @(posedge clk_in) begin
    if (!rst_n) rx_en_q <= 1'b0;
    else        rx_en_q <= rx_enable;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n || clear_buff) begin
      state            <= IDLE;
      waitrequest_out  <= 1'b1;
      wr_en            <= '0;
      wr_data          <= '0;
      wr_addr          <= '0;
      rx_done          <= 1'b0;
      watchdog_trigger <= 1'b0;
      overflow_err     <= 1'b0;
      dest_q           <= '0;
      exp_q            <= '0;
      word_cnt         <= '0;
      wd_cnt           <= '0;
    end else begin
      wr_en   <= '0;
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          waitrequest_out  <= 1'b1;
          watchdog_trigger <= 1'b0;
          if (rise) begin
            dest_q   <= dest_sel;
            exp_q    <= expected_words;
            word_cnt <= '0;
            wd_cnt   <= watchdog_conf;
            if (expected_words == '0) begin
              state   <= DONE;
              rx_done <= 1'b1;
            end else begin
              state           <= RECV;
              waitrequest_out <= 1'b0;
            end
          end
        end

        RECV: begin
          if (!rx_enable) begin
            state           <= IDLE;
            waitrequest_out <= 1'b1;
          end else begin
            if (word_valid) begin
              wr_en    <= N_DEST'(1) << dest_q;
              wr_data  <= packed_word;
              wr_addr  <= word_cnt[ADDR_W-1:0];
              word_cnt <= word_cnt_nxt;
              if ((word_cnt >> ADDR_W) != '0) overflow_err <= 1'b1;
              if (word_cnt_nxt == exp_q) begin
                state           <= DONE;
                rx_done         <= 1'b1;
                waitrequest_out <= 1'b1;
              end
            end
            // Down-counter from watchdog_conf, reloaded on every accepted beat;
            // terminal count 0 seen on the next idle cycle means conf+1 idle cycles.
            if (accept) begin
              wd_cnt <= watchdog_conf;
            end else if (watchdog_conf != '0) begin
              if (wd_cnt == '0) begin
                state            <= TIMEOUT;
                watchdog_trigger <= 1'b1;
                waitrequest_out  <= 1'b1;
              end else begin
                wd_cnt <= wd_cnt - 1'b1;
              end
            end
          end
        end

        DONE: begin
          waitrequest_out <= 1'b1;
          if (write) overflow_err <= 1'b1;
          if (!rx_enable) state <= IDLE;
        end

        TIMEOUT: begin
          waitrequest_out <= 1'b1;
          if (!rx_enable) begin
            state            <= IDLE;
            watchdog_trigger <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk_in) begin
    if (!rst_n || clear_buff)          csum <= '0;
    else if ((state == IDLE) && rise)  csum <= '0;
    else if (accept)                   csum <= csum + pio_data;
  end

  assign rx_checksum = csum;
`else
  assign rx_checksum = '0;
`endif

endmodule

// File: tb/tb_ahim_rx_router.sv
module tb_ahim_rx_router;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         clear_buff;
  logic         rx_enable;
  logic [0:0]   dest_sel;
  logic [15:0]  watchdog_conf;
  logic [15:0]  expected_words;
  logic [31:0]  pio_data;
  logic         write;
  logic         waitrequest_out;
  logic [1:0]   wr_en;
  logic [127:0] wr_data;
  logic [1:0]   wr_addr;
  logic         rx_done;
  logic         watchdog_trigger;
  logic         overflow_err;
  logic [31:0]  rx_checksum;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  ahim_rx_router #(
    .DATA_W(32), .BEATS_PER_WORD(4), .N_DEST(2), .ADDR_W(2), .CNT_W(16), .WD_W(16)
  ) dut (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .clear_buff      (clear_buff),
    .rx_enable       (rx_enable),
    .dest_sel        (dest_sel),
    .watchdog_conf   (watchdog_conf),
    .expected_words  (expected_words),
    .pio_data        (pio_data),
    .write           (write),
    .waitrequest_out (waitrequest_out),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_addr         (wr_addr),
    .rx_done         (rx_done),
    .watchdog_trigger(watchdog_trigger),
    .overflow_err    (overflow_err),
    .rx_checksum     (rx_checksum)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_buff = 1'b0; rx_enable = 1'b0; dest_sel = 1'b0;
    watchdog_conf = 16'd0; expected_words = 16'd0; pio_data = 32'd0; write = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_waitreq", waitrequest_out, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_trig", watchdog_trigger, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_csum", rx_checksum, 0);

    // Basic: 2 words to destination 1
    rx_enable = 1'b1; dest_sel = 1'b1; expected_words = 16'd2;
    tick();
    chk("basic_waitreq_recv", waitrequest_out, 0);
    for (int i = 1; i <= 8; i++) begin
      write = 1'b1; pio_data = 32'(i);
      tick();
      if (i == 4) begin
        chk("basic_w0_en", wr_en, 2'b10);
        chk("basic_w0_addr", wr_addr, 0);
        chk("basic_w0_data", wr_data, 128'h00000004_00000003_00000002_00000001);
        chk("basic_w0_done", rx_done, 0);
      end else if (i == 8) begin
        chk("basic_w1_en", wr_en, 2'b10);
        chk("basic_w1_addr", wr_addr, 1);
        chk("basic_w1_data", wr_data, 128'h00000008_00000007_00000006_00000005);
        chk("basic_w1_done", rx_done, 1);
        chk("basic_waitreq_after", waitrequest_out, 1);
      end else begin
        chk("basic_no_wr", wr_en, 0);
      end
    end
`ifndef RX_CHECKSUM_EN
    chk("csum_tied0", rx_checksum, 0);
`endif
    // Extra beat in DONE is dropped and flagged
    pio_data = 32'hDEAD;
    tick();
    write = 1'b0;
    chk("done_drop_wr", wr_en, 0);
    chk("done_drop_pulse", rx_done, 0);
    chk("done_ovf", overflow_err, 1);
    clear_buff = 1'b1;
    tick();
    clear_buff = 1'b0;
    chk("clear_ovf", overflow_err, 0);
    chk("clear_waitreq", waitrequest_out, 1);
    rx_enable = 1'b0;
    tick();

    // Watchdog: limit 5, stall mid-word
    watchdog_conf = 16'd5; dest_sel = 1'b0; expected_words = 16'd2;
    rx_enable = 1'b1;
    tick();
    write = 1'b1; pio_data = 32'h10; tick();
    pio_data = 32'h11; tick();
    write = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("wd_not_yet", watchdog_trigger, 0);
    chk("wd_not_yet_wr", waitrequest_out, 0);
    tick();
    chk("wd_trigger", watchdog_trigger, 1);
    chk("wd_waitreq", waitrequest_out, 1);
    chk("wd_no_wr", wr_en, 0);
    rx_enable = 1'b0;
    tick();
    chk("wd_clear", watchdog_trigger, 0);
    watchdog_conf = 16'd0;

    // Abort after 2 of 4 beats
    expected_words = 16'd1; rx_enable = 1'b1;
    tick();
    write = 1'b1; pio_data = 32'hA; tick();
    pio_data = 32'hB; tick();
    write = 1'b0; rx_enable = 1'b0;
    tick();
    chk("abort_no_wr", wr_en, 0);
    chk("abort_no_done", rx_done, 0);
    chk("abort_waitreq", waitrequest_out, 1);
    rx_enable = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      write = 1'b1; pio_data = 32'h10 + 32'(i);
      tick();
      if (i == 2) chk("abort_restart_partial", wr_en, 0);
    end
    write = 1'b0;
    chk("abort_restart_en", wr_en, 2'b01);
    chk("abort_restart_addr", wr_addr, 0);
    chk("abort_restart_data", wr_data, 128'h00000014_00000013_00000012_00000011);
    chk("abort_restart_done", rx_done, 1);
    rx_enable = 1'b0;
    tick();

    // Last beat coincides with rx_enable falling: abort wins
    rx_enable = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      write = 1'b1; pio_data = 32'(i); tick();
    end
    pio_data = 32'h4; rx_enable = 1'b0;
    tick();
    write = 1'b0;
    chk("simul_no_wr", wr_en, 0);
    chk("simul_no_done", rx_done, 0);
    tick();
    chk("simul_no_wr2", wr_en, 0);

    // Address wrap with ADDR_W=2, 5 words
    expected_words = 16'd5; rx_enable = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      write = 1'b1; pio_data = 32'(i);
      tick();
      if (i == 16) begin
        chk("wrap_w3_addr", wr_addr, 3);
        chk("wrap_w3_ovf", overflow_err, 0);
      end
    end
    write = 1'b0;
    chk("wrap_w4_en", wr_en, 2'b01);
    chk("wrap_w4_addr", wr_addr, 0);
    chk("wrap_w4_data", wr_data, 128'h00000014_00000013_00000012_00000011);
    chk("wrap_ovf", overflow_err, 1);
    chk("wrap_done", rx_done, 1);
    rx_enable = 1'b0;
    tick(); tick();
    chk("wrap_ovf_sticky", overflow_err, 1);
    clear_buff = 1'b1;
    tick();
    clear_buff = 1'b0;
    chk("wrap_ovf_cleared", overflow_err, 0);

    // expected_words == 0
    expected_words = 16'd0; rx_enable = 1'b1;
    tick();
    chk("zero_done", rx_done, 1);
    chk("zero_no_wr", wr_en, 0);
    chk("zero_waitreq", waitrequest_out, 1);
    tick();
    chk("zero_done_pulse", rx_done, 0);
    rx_enable = 1'b0;
    tick();

`ifdef RX_CHECKSUM_EN
    expected_words = 16'd1; rx_enable = 1'b1;
    tick();
    write = 1'b1; pio_data = 32'hFFFFFFFF; tick();
    pio_data = 32'h2; tick();
    pio_data = 32'h3; tick();
    pio_data = 32'h4; tick();
    write = 1'b0;
    chk("csum_done", rx_done, 1);
    chk("csum_value", rx_checksum, 32'h00000008);
    tick();
    chk("csum_stable", rx_checksum, 32'h00000008);
    rx_enable = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
